ms_delay_sched: RTL and testbench

- Shares one 1 ms timebase (the LFSR 1 ms tick generator) among N requesters that each need a millisecond delay, e.g. character-hold, inter-dot gap and feedback-beep timing in the trainer.
- Arbitrates between the requesters and restarts the timebase on every grant.
- Counts tick pulses down from the granted requester's delay, then returns a one-cycle done pulse.
- Sits between the trainer control FSMs and the single tick generator instance.

---
 rtl/ms_delay_sched_pkg.sv | 30 +++
 rtl/ms_delay_rr_pick.sv | 41 ++++
 rtl/ms_delay_sched.sv | 133 +++++++++++++
 tb/tb_ms_delay_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ms_delay_sched_pkg.sv
// ms_delay_sched_pkg: shared types and helpers for the millisecond delay scheduler.
// Build option: MS_DELAY_SCHED_RR_EN (see ms_delay_sched).
package ms_delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } st_e;

    localparam int DEF_N       = 4;
    localparam int DEF_DW      = 8;
    localparam int SLICE_BUS_W = 256;
    localparam int SLICE_W     = 32;

    // Generic slice extractor; caller narrows the result to its own DW.
    function automatic logic [SLICE_W-1:0] delay_slice(
        input logic [SLICE_BUS_W-1:0] bus,
        input int                     i,
        input int                     dw
    );
        logic [SLICE_BUS_W-1:0] sh;
        logic [SLICE_W-1:0]     mask;
        sh   = bus >> (i * dw);
        mask = (SLICE_W'(1) << dw) - SLICE_W'(1);
        return SLICE_W'(sh) & mask;
    endfunction

endpackage

// File: rtl/ms_delay_rr_pick.sv
// ms_delay_rr_pick: combinational N-way winner select, one-hot plus index.
// MS_DELAY_SCHED_RR_EN: round-robin from ptr; otherwise lowest index wins.
module ms_delay_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
`ifdef MS_DELAY_SCHED_RR_EN
    input  logic [IW-1:0] ptr,
`endif
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        jj     = '0;
        for (int k = 0; k < N; k++) begin
`ifdef MS_DELAY_SCHED_RR_EN
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
`else
            j = k;
`endif
            jj = IW'(j);
            if (!any && req[jj]) begin
                any        = 1'b1;
                idx        = jj;
                onehot[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ms_delay_sched.sv
// ms_delay_sched: shares one 1 ms timebase among N millisecond-delay requesters.
// Define MS_DELAY_SCHED_RR_EN for round-robin arbitration (default: fixed priority).
module ms_delay_sched
    import ms_delay_sched_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] delay_ms,
    input  logic            tick_1ms,
    output logic            tick_clr,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    st_e           state;
    logic [DW-1:0] remaining;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [DW-1:0] pick_delay;
    logic          held;

`ifdef MS_DELAY_SCHED_RR_EN
    logic [IW-1:0] ptr;
    logic [IW-1:0] cur;
    logic [IW-1:0] nxt;

    assign nxt = (cur == IW'(N - 1)) ? '0 : cur + IW'(1);
`endif

    ms_delay_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
`ifdef MS_DELAY_SCHED_RR_EN
        .ptr    (ptr),
`endif
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign pick_delay = DW'(delay_slice(SLICE_BUS_W'(delay_ms),
                                        int'(pick_idx), DW));

    // The served requester is the one whose grant bit is still set.
    assign held = |(req & gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            tick_clr  <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
`ifdef MS_DELAY_SCHED_RR_EN
            ptr       <= '0;
            cur       <= '0;
`endif
        end else begin
            done     <= '0;
            tick_clr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= LOAD;
                        gnt       <= pick_oh;
                        remaining <= pick_delay;
                        tick_clr  <= 1'b1;
                        busy      <= 1'b1;
`ifdef MS_DELAY_SCHED_RR_EN
                        cur       <= pick_idx;
`endif
                    end
                end
                LOAD: begin
                    if (!held) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
`ifdef MS_DELAY_SCHED_RR_EN
                        ptr   <= nxt;
`endif
                    end else if (remaining == '0) begin
                        state <= DONE;
                        gnt   <= '0;
                        done  <= gnt;
                    end else begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    // Abandon takes priority over a coincident final tick.
                    if (!held) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
`ifdef MS_DELAY_SCHED_RR_EN
                        ptr   <= nxt;
`endif
                    end else if (tick_1ms) begin
                        remaining <= remaining - DW'(1);
                        if (remaining == DW'(1)) begin
                            state <= DONE;
                            gnt   <= '0;
                            done  <= gnt;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef MS_DELAY_SCHED_RR_EN
                    ptr   <= nxt;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_delay_sched.sv
// tb_ms_delay_sched: directed plus randomized transactions against a
// transaction-level arbitration/timing model of ms_delay_sched.
`timescale 1ns/1ps
module tb_ms_delay_sched;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] delay_ms;
    logic            tick_1ms;
    logic            tick_clr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;
    int dly[N];

    always #10 clk = ~clk;

    ms_delay_sched #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .delay_ms (delay_ms),
        .tick_1ms (tick_1ms),
        .tick_clr (tick_clr),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: fixed priority or round-robin from mptr.
    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
`ifdef MS_DELAY_SCHED_RR_EN
            int j = (mptr + k) % N;
`else
            int j = k;
`endif
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive_delays();
        for (int i = 0; i < N; i++) delay_ms[i*DW +: DW] = DW'(dly[i]);
    endtask

    // One request from IDLE; ab_tick>0 drops the winner's req after
    // (or, with ab_coinc, together with) that tick.
    task automatic txn(input logic [N-1:0] r, input int ab_tick,
                       input bit ab_coinc);
        int w;
        int d;
        logic [N-1:0] oh;
        drive_delays();
        req      = r;
        tick_1ms = 1'b0;
        w        = pick(r);
        oh       = N'(1) << w;
        d        = dly[w];
        cyc();
        chk("grant", gnt, oh);
        chk("tick_clr_load", tick_clr, 1);
        chk("busy_load", busy, 1);
        chk("done_load", done, 0);
        tick_1ms = 1'($urandom_range(0, 1));
        cyc();
        tick_1ms = 1'b0;
        if (d != 0) begin
            chk("tick_clr_count", tick_clr, 0);
            chk("gnt_count", gnt, oh);
            chk("done_count", done, 0);
            for (int t = 1; t <= d; t++) begin
                int gap = $urandom_range(0, 3);
                repeat (gap) begin
                    req = N'($urandom) | oh;
                    cyc();
                    chk("gnt_hold", gnt, oh);
                    chk("done_early", done, 0);
                end
                tick_1ms = 1'b1;
                if (t == ab_tick && ab_coinc) req = req & ~oh;
                cyc();
                tick_1ms = 1'b0;
                if (t == ab_tick) begin
                    if (!ab_coinc) begin
                        req = req & ~oh;
                        cyc();
                    end
                    chk("abandon_gnt", gnt, 0);
                    chk("abandon_done", done, 0);
                    chk("abandon_busy", busy, 0);
                    req  = '0;
                    mptr = (w + 1) % N;
                    return;
                end
                if (t < d) begin
                    chk("done_mid", done, 0);
                    chk("gnt_mid", gnt, oh);
                end
            end
        end
        chk("done_pulse", done, oh);
        chk("gnt_off", gnt, 0);
        chk("busy_done", busy, 1);
        req = '0;
        cyc();
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
        chk("gnt_idle", gnt, 0);
        mptr = (w + 1) % N;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        tick_1ms = 1'b0;
        delay_ms = '0;
        for (int i = 0; i < N; i++) dly[i] = 1;

        repeat (3) begin
            cyc();
            chk("rst_gnt", gnt, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tick_clr", tick_clr, 0);
        end
        rst  = 1'b0;
        mptr = 0;
        dly  = '{2, 1, 3, 0};
        txn(4'b1111, -1, 1'b0);

        dly = '{0, 3, 0, 0};
        txn(4'b0010, -1, 1'b0);

        dly = '{0, 4, 4, 4};
        txn(4'b0001, -1, 1'b0);

        dly = '{1, 1, 1, 1};
        repeat (5) txn(4'b1111, -1, 1'b0);

        dly = '{1, 1, 5, 1};
        txn(4'b0100, 2, 1'b0);
        txn(4'b0100, 5, 1'b1);

        // Reset while counting with four ticks still outstanding.
        dly = '{0, 6, 0, 0};
        drive_delays();
        req = 4'b0010;
        cyc();
        cyc();
        repeat (2) begin
            tick_1ms = 1'b1;
            cyc();
            tick_1ms = 1'b0;
        end
        chk("pre_rst_gnt", gnt, 4'b0010);
        rst = 1'b1;
        cyc();
        chk("midrst_gnt", gnt, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tick_clr", tick_clr, 0);
        rst  = 1'b0;
        req  = '0;
        mptr = 0;
        cyc();
        chk("post_rst_busy", busy, 0);
        dly = '{2, 3, 1, 2};
        txn(4'b1010, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [N-1:0] r;
            int ab;
            for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 5);
            r  = N'($urandom_range(1, 15));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : -1;
            txn(r, ab, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
